ucsbece154b_bpu: RTL and testbench

Parametrised branch prediction unit for the five-stage pipeline. It combines a tagged direct-mapped BTB, a PHT of 2-bit counters, and a speculative global history register with repair. A MODE parameter selects static not-taken, bimodal or gshare direction prediction. The unit predicts combinationally in Fetch and trains and repairs from Execute. It also reports mispredicts and keeps saturating performance counters.

---
 rtl/ucsbece154b_bpu_if.sv | 47 ++++
 rtl/ucsbece154b_bpu.sv | 124 ++++++++++++
 tb/tb_ucsbece154b_bpu.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ucsbece154b_bpu_if.sv
// Fetch/Execute-side signal bundle of the branch prediction unit.
// The pipeline holds the master end; the predictor holds the slave end.
interface ucsbece154b_bpu_if #(
  parameter int NUM_GHR_BITS = 6,
  parameter int CNT_WIDTH    = 32
);
  logic                    pc_f_i_unused_guard;
  logic [31:0]             pc_f_i;
  logic                    stall_f_i;
  logic                    predtaken_f_o;
  logic [31:0]             predtarget_f_o;
  logic [NUM_GHR_BITS-1:0] phtidx_f_o;
  logic [NUM_GHR_BITS-1:0] ghr_f_o;
  logic                    res_valid_e_i;
  logic                    res_isbranch_e_i;
  logic                    res_isjump_e_i;
  logic                    res_taken_e_i;
  logic [31:0]             res_pc_e_i;
  logic [31:0]             res_target_e_i;
  logic                    res_predtaken_e_i;
  logic [31:0]             res_predtarget_e_i;
  logic [NUM_GHR_BITS-1:0] res_phtidx_e_i;
  logic [NUM_GHR_BITS-1:0] res_ghr_e_i;
  logic                    mispredict_e_o;
  logic [CNT_WIDTH-1:0]    branch_count_o;
  logic [CNT_WIDTH-1:0]    mispredict_count_o;

  assign pc_f_i_unused_guard = 1'b0;

  modport master (
    output pc_f_i, stall_f_i,
    output res_valid_e_i, res_isbranch_e_i, res_isjump_e_i, res_taken_e_i,
    output res_pc_e_i, res_target_e_i, res_predtaken_e_i, res_predtarget_e_i,
    output res_phtidx_e_i, res_ghr_e_i,
    input  predtaken_f_o, predtarget_f_o, phtidx_f_o, ghr_f_o,
    input  mispredict_e_o, branch_count_o, mispredict_count_o
  );

  modport slave (
    input  pc_f_i, stall_f_i,
    input  res_valid_e_i, res_isbranch_e_i, res_isjump_e_i, res_taken_e_i,
    input  res_pc_e_i, res_target_e_i, res_predtaken_e_i, res_predtarget_e_i,
    input  res_phtidx_e_i, res_ghr_e_i,
    output predtaken_f_o, predtarget_f_o, phtidx_f_o, ghr_f_o,
    output mispredict_e_o, branch_count_o, mispredict_count_o
  );
endinterface

// File: rtl/ucsbece154b_bpu.sv
// Branch prediction unit: tagged direct-mapped BTB, 2-bit PHT (static/bimodal/gshare)
// and a speculative global history register repaired from Execute.
module ucsbece154b_bpu #(
  parameter int NUM_BTB_ENTRIES = 64,
  parameter int NUM_GHR_BITS    = 6,
  parameter int TAG_BITS        = 8,
  parameter int MODE            = 2,
  parameter int CNT_WIDTH       = 32
) (
  input  logic             clk,
  input  logic             reset_ni,
  ucsbece154b_bpu_if.slave bus
);
  localparam int IW = $clog2(NUM_BTB_ENTRIES);
  localparam int G  = NUM_GHR_BITS;
  localparam int PN = 1 << G;

  logic [NUM_BTB_ENTRIES-1:0] r_btb_vld;
  logic [NUM_BTB_ENTRIES-1:0] r_btb_jmp;
  logic [TAG_BITS-1:0]        r_btb_tag [NUM_BTB_ENTRIES];
  logic [31:0]                r_btb_tgt [NUM_BTB_ENTRIES];
  logic [1:0]                 r_pht [PN];
  logic [G-1:0]               r_ghr;
  logic [CNT_WIDTH-1:0]       r_br_cnt;
  logic [CNT_WIDTH-1:0]       r_mp_cnt;

  logic [IW-1:0]       w_f_idx;
  logic [TAG_BITS-1:0] w_f_tag;
  logic                w_f_hit;
  logic [G-1:0]        w_f_phtidx;
  logic                w_f_dir;
  logic                w_f_taken;
  logic                w_f_cond;

  assign w_f_idx = bus.pc_f_i[2 +: IW];
  assign w_f_tag = bus.pc_f_i[2+IW +: TAG_BITS];
  assign w_f_hit = r_btb_vld[w_f_idx] && (r_btb_tag[w_f_idx] == w_f_tag);

  generate
    if (MODE == 2) begin : g_gshare
      assign w_f_phtidx = bus.pc_f_i[2 +: G] ^ r_ghr;
    end else if (MODE == 1) begin : g_bimodal
      assign w_f_phtidx = bus.pc_f_i[2 +: G];
    end else begin : g_static
      assign w_f_phtidx = '0;
    end
  endgenerate

  assign w_f_dir   = (MODE != 0) && r_pht[w_f_phtidx][1];
  assign w_f_taken = w_f_hit && (r_btb_jmp[w_f_idx] || w_f_dir);
  assign w_f_cond  = w_f_hit && !r_btb_jmp[w_f_idx];

  assign bus.predtaken_f_o  = w_f_taken;
  assign bus.predtarget_f_o = w_f_taken ? r_btb_tgt[w_f_idx] : bus.pc_f_i + 32'd4;
  assign bus.phtidx_f_o     = w_f_phtidx;
  assign bus.ghr_f_o        = r_ghr;

  logic [IW-1:0]       w_r_idx;
  logic [TAG_BITS-1:0] w_r_tag;
  logic                w_r_br;
  logic                w_mispred;
  logic                w_btb_we;
  logic                w_pht_we;
  logic [1:0]          w_pht_old;
  logic [1:0]          w_pht_new;
  logic [G-1:0]        w_ghr_nxt;

  assign w_r_idx   = bus.res_pc_e_i[2 +: IW];
  assign w_r_tag   = bus.res_pc_e_i[2+IW +: TAG_BITS];
  assign w_r_br    = bus.res_valid_e_i && bus.res_isbranch_e_i;
  assign w_mispred = bus.res_valid_e_i && (bus.res_isbranch_e_i || bus.res_isjump_e_i) &&
                     ((bus.res_taken_e_i != bus.res_predtaken_e_i) ||
                      (bus.res_taken_e_i && (bus.res_target_e_i != bus.res_predtarget_e_i)));
  assign w_btb_we  = bus.res_valid_e_i && bus.res_taken_e_i;
  assign w_pht_we  = w_r_br && (MODE != 0);
  assign w_pht_old = r_pht[bus.res_phtidx_e_i];

  always_comb begin
    w_pht_new = w_pht_old;
    if (bus.res_taken_e_i && (w_pht_old != 2'b11))       w_pht_new = w_pht_old + 2'b01;
    else if (!bus.res_taken_e_i && (w_pht_old != 2'b00)) w_pht_new = w_pht_old - 2'b01;
  end

  // Repair from Execute wins over the speculative shift from Fetch.
  always_comb begin
    w_ghr_nxt = r_ghr;
    if (w_mispred && bus.res_isbranch_e_i) w_ghr_nxt = {bus.res_ghr_e_i[G-2:0], bus.res_taken_e_i};
    else if (w_mispred)                    w_ghr_nxt = bus.res_ghr_e_i;
    else if (!bus.stall_f_i && w_f_cond)   w_ghr_nxt = {r_ghr[G-2:0], w_f_taken};
  end

  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      r_btb_vld <= '0;
      r_ghr     <= '0;
      r_br_cnt  <= '0;
      r_mp_cnt  <= '0;
      for (int i = 0; i < PN; i++) r_pht[i] <= 2'b01;
    end else begin
      r_ghr <= w_ghr_nxt;
      if (w_btb_we)                r_btb_vld[w_r_idx] <= 1'b1;
      if (w_pht_we)                r_pht[bus.res_phtidx_e_i] <= w_pht_new;
      if (w_r_br && ~&r_br_cnt)    r_br_cnt <= r_br_cnt + 1'b1;
      if (w_mispred && ~&r_mp_cnt) r_mp_cnt <= r_mp_cnt + 1'b1;
    end
  end

  // Entry payload needs no reset; the valid bit guards it.
  always_ff @(posedge clk) begin
    if (reset_ni && w_btb_we) begin
      r_btb_tag[w_r_idx] <= w_r_tag;
      r_btb_tgt[w_r_idx] <= bus.res_target_e_i;
      r_btb_jmp[w_r_idx] <= bus.res_isjump_e_i;
    end
  end

  assign bus.mispredict_e_o     = w_mispred;
  assign bus.branch_count_o     = r_br_cnt;
  assign bus.mispredict_count_o = r_mp_cnt;

  logic w_unused;
  assign w_unused = ^{bus.pc_f_i[1:0], bus.pc_f_i[31:2+IW+TAG_BITS],
                      bus.res_pc_e_i[1:0], bus.res_pc_e_i[31:2+IW+TAG_BITS]};
endmodule

// File: tb/tb_ucsbece154b_bpu.sv
// Drives identical stimulus into MODE 0/1/2 instances and compares them against a
// behavioural predictor model (arrays + arithmetic) kept here.
module tb_ucsbece154b_bpu;
  localparam int NB = 64, G = 6, TB = 8, CW = 8;
  localparam int CMAX = (1 << CW) - 1;
  localparam int GM   = (1 << G) - 1;

  logic clk = 1'b0;
  logic reset_ni;
  always #5 clk = ~clk;

  logic [31:0] pc, rpc, rtgt, rptgt;
  logic        stall, rv, rbr, rj, rt, rpt;
  logic [G-1:0] rpidx, rghr;

  logic [2:0]         o_pt, o_mp;
  logic [2:0][31:0]   o_tgt;
  logic [2:0][G-1:0]  o_idx, o_ghr;
  logic [2:0][CW-1:0] o_bc, o_mc;

  for (genvar m = 0; m < 3; m++) begin : g_dut
    ucsbece154b_bpu_if #(.NUM_GHR_BITS(G), .CNT_WIDTH(CW)) u_if ();
    assign u_if.pc_f_i             = pc;
    assign u_if.stall_f_i          = stall;
    assign u_if.res_valid_e_i      = rv;
    assign u_if.res_isbranch_e_i   = rbr;
    assign u_if.res_isjump_e_i     = rj;
    assign u_if.res_taken_e_i      = rt;
    assign u_if.res_pc_e_i         = rpc;
    assign u_if.res_target_e_i     = rtgt;
    assign u_if.res_predtaken_e_i  = rpt;
    assign u_if.res_predtarget_e_i = rptgt;
    assign u_if.res_phtidx_e_i     = rpidx;
    assign u_if.res_ghr_e_i        = rghr;
    assign o_pt[m]  = u_if.predtaken_f_o;
    assign o_tgt[m] = u_if.predtarget_f_o;
    assign o_idx[m] = u_if.phtidx_f_o;
    assign o_ghr[m] = u_if.ghr_f_o;
    assign o_mp[m]  = u_if.mispredict_e_o;
    assign o_bc[m]  = u_if.branch_count_o;
    assign o_mc[m]  = u_if.mispredict_count_o;
    ucsbece154b_bpu #(.NUM_BTB_ENTRIES(NB), .NUM_GHR_BITS(G), .TAG_BITS(TB),
                      .MODE(m), .CNT_WIDTH(CW)) u_dut (
      .clk(clk), .reset_ni(reset_ni), .bus(u_if));
  end

  // reference model state
  bit          m_v [NB];
  int          m_tag [NB];
  logic [31:0] m_tgt [NB];
  bit          m_j [NB];
  int          m_pht [3][64];
  int          m_ghr [3];
  int          m_bc, m_mc;
  int          n_chk = 0, n_fail = 0;

  logic [31:0] pool [8] = '{32'h100, 32'h200, 32'h104, 32'h500,
                            32'h108, 32'h3f0, 32'h1100, 32'h204};

  function automatic int bi(logic [31:0] a); return int'((a >> 2) % NB); endfunction
  function automatic int bt(logic [31:0] a); return int'((a >> 8) % 256); endfunction
  function automatic bit hit(logic [31:0] a);
    return m_v[bi(a)] && (m_tag[bi(a)] == bt(a));
  endfunction
  function automatic int pidx(int m, logic [31:0] a);
    int b = int'((a >> 2) % 64);
    if (m == 2) return b ^ m_ghr[2];
    if (m == 1) return b;
    return 0;
  endfunction
  function automatic bit ptk(int m, logic [31:0] a);
    return hit(a) && (m_j[bi(a)] || (m != 0 && m_pht[m][pidx(m, a)] >= 2));
  endfunction
  function automatic bit mpx();
    return rv && (rbr || rj) && ((rt != rpt) || (rt && (rtgt != rptgt)));
  endfunction

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic idle();
    rv = 0; rbr = 0; rj = 0; rt = 0; rpt = 0; stall = 0;
    rpc = '0; rtgt = '0; rptgt = '0; rpidx = '0; rghr = '0;
  endtask

  // advance the model across one rising edge using the inputs currently driven
  task automatic upd();
    bit mp;
    if (!reset_ni) begin
      for (int i = 0; i < NB; i++) m_v[i] = 0;
      for (int m = 0; m < 3; m++) begin
        m_ghr[m] = 0;
        for (int i = 0; i < 64; i++) m_pht[m][i] = 1;
      end
      m_bc = 0; m_mc = 0;
      return;
    end
    mp = mpx();
    for (int m = 0; m < 3; m++) begin
      bit h = hit(pc);
      bit t = ptk(m, pc);
      if (mp && rbr)                           m_ghr[m] = ((int'(rghr) << 1) | int'(rt)) & GM;
      else if (mp)                             m_ghr[m] = int'(rghr);
      else if (!stall && h && !m_j[bi(pc)])    m_ghr[m] = ((m_ghr[m] << 1) | int'(t)) & GM;
      if (rv && rbr && m != 0) begin
        if (rt && m_pht[m][rpidx] < 3)       m_pht[m][rpidx]++;
        else if (!rt && m_pht[m][rpidx] > 0) m_pht[m][rpidx]--;
      end
    end
    if (rv && rt) begin
      m_v[bi(rpc)] = 1; m_tag[bi(rpc)] = bt(rpc); m_tgt[bi(rpc)] = rtgt; m_j[bi(rpc)] = rj;
    end
    if (rv && rbr && m_bc < CMAX) m_bc++;
    if (mp && m_mc < CMAX)        m_mc++;
  endtask

  task automatic cyc();
    #1;
    for (int m = 0; m < 3; m++) begin
      bit t = ptk(m, pc);
      chk($sformatf("pt_m%0d", m),  o_pt[m],  t);
      chk($sformatf("tgt_m%0d", m), o_tgt[m], t ? m_tgt[bi(pc)] : pc + 32'd4);
      chk($sformatf("idx_m%0d", m), o_idx[m], pidx(m, pc));
      chk($sformatf("ghr_m%0d", m), o_ghr[m], m_ghr[m]);
      chk($sformatf("mp_m%0d", m),  o_mp[m],  mpx());
      chk($sformatf("bc_m%0d", m),  o_bc[m],  m_bc);
      chk($sformatf("mc_m%0d", m),  o_mc[m],  m_mc);
    end
    @(posedge clk);
    upd();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_ni = 0; idle();
    @(posedge clk);
    upd();
    @(negedge clk);
    reset_ni = 1;
  endtask

  initial begin
    pc = 32'h100; idle(); do_reset();

    // reset state
    cyc();
    chk("rst_pt", o_pt[2], 0); chk("rst_tgt", o_tgt[2], 32'h104);
    chk("rst_bc", o_bc[2], 0); chk("rst_mp", o_mp[2], 0);

    // taken beq at 0x100 -> 0x80, first seen as not-taken
    rv = 1; rbr = 1; rt = 1; rpc = 32'h100; rtgt = 32'h80; rpt = 0; rptgt = 32'h104;
    #1 chk("beq_mp", o_mp[1], 1);
    cyc(); idle(); #1;
    chk("beq_pt", o_pt[1], 1); chk("beq_tgt", o_tgt[1], 32'h80); chk("beq_mc", o_mc[1], 1);
    cyc();

    // jal 0x200 -> 0x400 predicts taken in every mode
    rv = 1; rj = 1; rt = 1; rpc = 32'h200; rtgt = 32'h400; rptgt = 32'h204;
    cyc(); idle(); pc = 32'h200; #1;
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("jal_pt_m%0d", m), o_pt[m], 1);
      chk($sformatf("jal_tgt_m%0d", m), o_tgt[m], 32'h400);
    end
    cyc(); cyc();
    chk("jal_pt_m0_again", o_pt[0], 1);

    // speculative shift and repair in the same cycle
    rv = 1; rbr = 1; rt = 1; rpc = 32'h100; rtgt = 32'h80; rptgt = 32'h104;
    cyc(); idle();
    pc = 32'h100; rv = 1; rbr = 1; rt = 1; rpt = 0; rpc = 32'h304; rtgt = 32'h10;
    rptgt = 32'h308; rghr = 6'b000001; rpidx = 6'd5;
    cyc();
    chk("rep_ghr", o_ghr[2], 6'b000011);

    // stall freezes history
    idle(); stall = 1; pc = 32'h100;
    cyc(); cyc(); cyc();
    chk("stall_ghr", o_ghr[2], 6'b000011);
    stall = 0;

    // reset during an active resolve
    reset_ni = 0; rv = 1; rj = 1; rt = 1; rpc = 32'h700; rtgt = 32'h900;
    cyc();
    reset_ni = 1; idle(); pc = 32'h700; #1;
    chk("rstw_pt", o_pt[0], 0); chk("rstw_tgt", o_tgt[0], 32'h704);
    chk("rstw_bc", o_bc[2], 0); chk("rstw_ghr", o_ghr[2], 0);
    cyc();

    // gshare learns an alternating loop branch
    do_reset();
    for (int k = 0; k < 20; k++) begin
      bit p; logic [31:0] ptg; int pi, gh;
      idle(); pc = 32'h500;
      p = ptk(2, pc); ptg = p ? m_tgt[bi(pc)] : pc + 32'd4; pi = pidx(2, pc); gh = m_ghr[2];
      cyc();
      idle(); pc = 32'h600;
      rv = 1; rbr = 1; rt = (k % 2 == 0); rpc = 32'h500; rtgt = 32'h480;
      rpt = p; rptgt = ptg; rpidx = G'(pi); rghr = G'(gh);
      #1 if (k >= 10) chk("loop_mp", o_mp[2], 0);
      cyc();
    end

    // branch counter saturation
    do_reset();
    pc = 32'h800;
    for (int i = 0; i < CMAX + 3; i++) begin
      rv = 1; rbr = 1; rt = 0; rpt = 0; rpc = 32'h900; rpidx = G'($urandom());
      cyc();
    end
    idle(); #1;
    chk("sat_bc", o_bc[2], CMAX);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      int k;
      reset_ni = ($urandom_range(0, 299) != 0);
      pc = ($urandom_range(0, 3) != 0) ? pool[$urandom_range(0, 7)] : $urandom();
      stall = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 9) < 7);
      k = $urandom_range(0, 2);
      rbr = (k == 0); rj = (k == 1);
      rt = rj ? 1'b1 : 1'($urandom_range(0, 1));
      rpc = pool[$urandom_range(0, 7)];
      rtgt = 32'($urandom_range(0, 15)) << 4;
      rpt = 1'($urandom_range(0, 1));
      rptgt = ($urandom_range(0, 1) != 0) ? rtgt : 32'($urandom_range(0, 15)) << 4;
      rpidx = G'($urandom()); rghr = G'($urandom());
      cyc();
    end
    reset_ni = 1; idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
